// File: rtl/npu_axi_dma_copy.sv
`default_nettype none
// ============================================================================
// Module      : npu_axi_dma_copy
// Description : Memory-to-memory copy engine. Accepts one descriptor
//               (src, dst, bytes) and moves the data in chunks: each chunk is
//               one AXI4 INCR read burst into an on-chip beat buffer followed
//               by one AXI4 INCR write burst. Reports completion or error with
//               a one-cycle pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   dma_req_*           descriptor request (valid/ready, src, dst, bytes)
//   dma_resp_done/err   one-cycle completion / abort pulses
//   dma_busy            high from accept until the done/err pulse
//   m_axi_ar*/r*        AXI4 read address / read data channels
//   m_axi_aw*/w*/b*     AXI4 write address / write data / write response
// ============================================================================
module npu_axi_dma_copy #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 256,
  parameter int LEN_W     = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // descriptor interface
  input  logic                  dma_req_valid,
  output logic                  dma_req_ready,
  input  logic [ADDR_W-1:0]     dma_req_src,
  input  logic [ADDR_W-1:0]     dma_req_dst,
  input  logic [LEN_W-1:0]      dma_req_bytes,
  output logic                  dma_resp_done,
  output logic                  dma_resp_err,
  output logic                  dma_busy,
  // AXI read address
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  // AXI read data
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  // AXI write address
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  // AXI write data
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  // AXI write response
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp
);

  localparam int STRB_W     = DATA_W / 8;
  localparam int c_lg       = $clog2(STRB_W);                       // log2(bytes per beat)
  localparam int c_idx_w    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [1:0] c_resp_okay  = 2'b00;
  localparam logic [1:0] c_burst_incr = 2'b01;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CALC  = 4'd1,
    S_AR    = 4'd2,
    S_R     = 4'd3,
    S_DRAIN = 4'd4,
    S_AW    = 4'd5,
    S_W     = 4'd6,
    S_B     = 4'd7,
    S_DONE  = 4'd8,
    S_ERR   = 4'd9
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [LEN_W:0]      r_rem;      // one extra bit so byte math never overflows
  logic [8:0]          r_chunk;    // beats in the current burst, 1..MAX_BEATS
  logic [8:0]          r_beat;     // beat index within the current burst

  logic [DATA_W-1:0]   r_buf [MAX_BEATS];

  logic [LEN_W:0]      w_rem_beats;
  logic [12:0]         w_src_room;
  logic [12:0]         w_dst_room;
  logic [8:0]          w_chunk;
  logic                w_misalign;
  logic                w_beat_last;
  logic [LEN_W:0]      w_chunk_bytes;
  logic [ADDR_W-1:0]   w_chunk_addr;
  logic                w_last_chunk;
  logic [c_lg-1:0]     w_tail;
  logic                w_r_bad;

  // --------------------------------------------------------------------------
  // Chunk sizing: limited by remaining beats, buffer depth and the distance
  // of both src and dst to their next 4KB page (AXI bursts must not cross).
  // --------------------------------------------------------------------------
  always_comb begin
    w_rem_beats = (r_rem + (LEN_W+1)'(STRB_W - 1)) >> c_lg;
    w_src_room  = (13'd4096 - {1'b0, r_src[11:0]}) >> c_lg;
    w_dst_room  = (13'd4096 - {1'b0, r_dst[11:0]}) >> c_lg;
    w_chunk     = 9'(MAX_BEATS);
    if ({4'd0, w_chunk} > w_src_room) begin
      w_chunk = w_src_room[8:0];
    end
    if ({4'd0, w_chunk} > w_dst_room) begin
      w_chunk = w_dst_room[8:0];
    end
    if ((LEN_W+1)'(w_chunk) > w_rem_beats) begin
      w_chunk = w_rem_beats[8:0];
    end
  end

  assign w_misalign    = (|r_src[c_lg-1:0]) || (|r_dst[c_lg-1:0]);
  assign w_beat_last   = (r_beat == (r_chunk - 9'd1));
  assign w_chunk_bytes = (LEN_W+1)'(r_chunk) << c_lg;
  assign w_chunk_addr  = ADDR_W'(r_chunk) << c_lg;
  // The current chunk finishes the copy when it covers all remaining bytes.
  assign w_last_chunk  = (r_rem <= w_chunk_bytes);
  assign w_tail        = r_rem[c_lg-1:0];
  // A read beat is bad on an error response or when rlast disagrees with
  // the expected burst length (early or missing).
  assign w_r_bad       = (m_axi_rresp != c_resp_okay) || (m_axi_rlast != w_beat_last);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (dma_req_valid) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (w_misalign) begin
          w_state_nxt = S_ERR;
        end else if (r_rem == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_AR;
        end
      end
      S_AR: begin
        if (m_axi_arready) begin
          w_state_nxt = S_R;
        end
      end
      S_R: begin
        if (m_axi_rvalid) begin
          if (w_r_bad) begin
            // burst already terminated by rlast: abort now, otherwise sink
            w_state_nxt = m_axi_rlast ? S_ERR : S_DRAIN;
          end else if (m_axi_rlast) begin
            w_state_nxt = S_AW;
          end
        end
      end
      S_DRAIN: begin
        if (m_axi_rvalid && m_axi_rlast) begin
          w_state_nxt = S_ERR;
        end
      end
      S_AW: begin
        if (m_axi_awready) begin
          w_state_nxt = S_W;
        end
      end
      S_W: begin
        if (m_axi_wready && w_beat_last) begin
          w_state_nxt = S_B;
        end
      end
      S_B: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != c_resp_okay) begin
            w_state_nxt = S_ERR;
          end else if (w_last_chunk) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_CALC;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Descriptor / progress datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_chunk <= '0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dma_req_valid) begin
            r_src <= dma_req_src;
            r_dst <= dma_req_dst;
            r_rem <= {1'b0, dma_req_bytes};
          end
        end
        S_CALC: begin
          r_chunk <= w_chunk;
          r_beat  <= '0;
        end
        S_R: begin
          if (m_axi_rvalid) begin
            r_beat <= m_axi_rlast ? 9'd0 : r_beat + 9'd1;
          end
        end
        S_W: begin
          if (m_axi_wready) begin
            r_beat <= w_beat_last ? 9'd0 : r_beat + 9'd1;
          end
        end
        S_B: begin
          if (m_axi_bvalid && (m_axi_bresp == c_resp_okay)) begin
            r_src <= r_src + w_chunk_addr;
            r_dst <= r_dst + w_chunk_addr;
            r_rem <= r_rem - (w_last_chunk ? r_rem : w_chunk_bytes);
          end
        end
        default: ;
      endcase
    end
  end

  // Beat buffer: payload only, no reset needed. In S_R the beat index never
  // exceeds chunk-1 because a missing rlast on that beat diverts to S_DRAIN.
  always_ff @(posedge clk) begin
    if ((r_state == S_R) && m_axi_rvalid) begin
      r_buf[r_beat[c_idx_w-1:0]] <= m_axi_rdata;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign dma_req_ready = (r_state == S_IDLE);
  assign dma_busy      = (r_state != S_IDLE);
  assign dma_resp_done = (r_state == S_DONE);
  assign dma_resp_err  = (r_state == S_ERR);

  assign m_axi_arvalid = (r_state == S_AR);
  assign m_axi_araddr  = r_src;
  assign m_axi_arlen   = 8'(r_chunk - 9'd1);
  assign m_axi_arsize  = 3'(c_lg);
  assign m_axi_arburst = c_burst_incr;

  assign m_axi_rready  = (r_state == S_R) || (r_state == S_DRAIN);

  assign m_axi_awvalid = (r_state == S_AW);
  assign m_axi_awaddr  = r_dst;
  assign m_axi_awlen   = 8'(r_chunk - 9'd1);
  assign m_axi_awsize  = 3'(c_lg);
  assign m_axi_awburst = c_burst_incr;

  // Write payload is a pure function of registered state, so it stays
  // stable while the slave stalls wready.
  assign m_axi_wvalid  = (r_state == S_W);
  assign m_axi_wdata   = r_buf[r_beat[c_idx_w-1:0]];
  assign m_axi_wlast   = w_beat_last;

  always_comb begin
    m_axi_wstrb = '1;
    // Only the very last beat of the copy can be partial.
    if (w_last_chunk && w_beat_last && (w_tail != '0)) begin
      m_axi_wstrb = ~({STRB_W{1'b1}} << w_tail);
    end
  end

  assign m_axi_bready  = (r_state == S_B);

endmodule
`default_nettype wire

// File: tb/tb_npu_axi_dma_copy.sv
`default_nettype none
// ============================================================================
// Module      : tb_npu_axi_dma_copy
// Description : Self-checking bench for npu_axi_dma_copy. A reactive AXI slave
//               with random stalls serves reads from a synthetic source
//               pattern and captures writes into a byte memory; a burst-level
//               reference model predicts every AR/AW and strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npu_axi_dma_copy;

  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 256;
  localparam int LEN_W     = 32;
  localparam int MAX_BEATS = 16;
  localparam int STRB_W    = DATA_W / 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                dma_req_valid, dma_req_ready;
  logic [ADDR_W-1:0]   dma_req_src, dma_req_dst;
  logic [LEN_W-1:0]    dma_req_bytes;
  logic                dma_resp_done, dma_resp_err, dma_busy;
  logic                m_axi_arvalid, m_axi_arready;
  logic [ADDR_W-1:0]   m_axi_araddr;
  logic [7:0]          m_axi_arlen;
  logic [2:0]          m_axi_arsize;
  logic [1:0]          m_axi_arburst;
  logic                m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [DATA_W-1:0]   m_axi_rdata;
  logic [1:0]          m_axi_rresp;
  logic                m_axi_awvalid, m_axi_awready;
  logic [ADDR_W-1:0]   m_axi_awaddr;
  logic [7:0]          m_axi_awlen;
  logic [2:0]          m_axi_awsize;
  logic [1:0]          m_axi_awburst;
  logic                m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [DATA_W-1:0]   m_axi_wdata;
  logic [STRB_W-1:0]   m_axi_wstrb;
  logic                m_axi_bvalid, m_axi_bready;
  logic [1:0]          m_axi_bresp;

  always #5 clk = ~clk;

  npu_axi_dma_copy #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BEATS(MAX_BEATS)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
    .dma_req_src(dma_req_src), .dma_req_dst(dma_req_dst), .dma_req_bytes(dma_req_bytes),
    .dma_resp_done(dma_resp_done), .dma_resp_err(dma_resp_err), .dma_busy(dma_busy),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp)
  );

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic ck(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // --------------------------------------------------------------------------
  // Reference model: list of bursts the copy must issue
  // --------------------------------------------------------------------------
  typedef struct { longint unsigned src; longint unsigned dst; int len; } burst_t;
  typedef struct { longint unsigned addr; int len; } ax_t;
  burst_t exp_q[$];
  ax_t    ar_q[$];
  ax_t    aw_q[$];

  task automatic build_model(input longint unsigned s, input longint unsigned d,
                             input longint unsigned n);
    longint unsigned c;
    exp_q.delete();
    while (n > 0) begin
      c = (n + 31) / 32;
      if (c > MAX_BEATS) c = MAX_BEATS;
      if (c > (4096 - s % 4096) / 32) c = (4096 - s % 4096) / 32;
      if (c > (4096 - d % 4096) / 32) c = (4096 - d % 4096) / 32;
      exp_q.push_back('{s, d, int'(c) - 1});
      s += c * 32;
      d += c * 32;
      n -= (n < c * 32) ? n : c * 32;
    end
  endtask

  logic [7:0] seed;
  function automatic logic [7:0] src_byte(input longint unsigned a);
    return 8'(a[7:0] * 8'd29) ^ a[15:8] ^ a[39:32] ^ seed;
  endfunction

  function automatic logic [255:0] mk_beat(input longint unsigned a);
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[8*i +: 8] = src_byte(a + longint'(i));
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // Reactive AXI slave + monitor (decides inputs at negedge for next posedge)
  // --------------------------------------------------------------------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int stall_pct = 0;
  int inj_burst = -1, inj_beat = -1;
  longint unsigned cur_bytes;
  int n_ar, n_aw, n_rb, n_rbeats, n_wbursts, n_wb_total, b_pend;
  int n_done, n_err, done_cyc, last_b_cyc, first_ar_cyc;
  bit ar_seen, aw_seen;
  int r_beat, w_beat;
  bit r_stuck, w_stuck, b_stuck;
  logic [DATA_W-1:0] sv_data;
  logic [STRB_W-1:0] sv_strb;
  logic              sv_last;
  logic [7:0] wmem [longint unsigned];

  function automatic bit stall();
    return $urandom_range(0, 99) < stall_pct;
  endfunction

  function automatic logic [31:0] exp_strb();
    longint unsigned tb = (cur_bytes + 31) / 32;
    longint unsigned tail = cur_bytes % 32;
    if (longint'(n_wb_total) == longint'(tb) - 1 && tail != 0)
      return 32'((64'd1 << tail) - 64'd1);
    return 32'hFFFF_FFFF;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 0; m_axi_rlast = 0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
      r_stuck = 0; w_stuck = 0; b_stuck = 0; r_beat = 0; w_beat = 0;
      ar_q.delete(); aw_q.delete();
    end else begin
      if (dma_resp_done) begin n_done++; done_cyc = cyc; end
      if (dma_resp_err) n_err++;
      // B channel (before W so a response never coincides with its wlast)
      if (!b_stuck) m_axi_bvalid = (b_pend > 0) && !stall();
      m_axi_bresp = 2'b00;
      if (m_axi_bvalid && m_axi_bready) begin
        b_pend--; last_b_cyc = cyc; b_stuck = 0;
      end else b_stuck = m_axi_bvalid;
      // R channel (before AR so data never coincides with its address)
      if (!r_stuck) begin
        m_axi_rvalid = (ar_q.size() > 0) && !stall();
        if (m_axi_rvalid) begin
          m_axi_rdata = mk_beat(ar_q[0].addr + longint'(32 * r_beat));
          m_axi_rresp = (n_rb == inj_burst && r_beat == inj_beat) ? 2'b10 : 2'b00;
          m_axi_rlast = (r_beat == ar_q[0].len);
        end
      end
      if (m_axi_rvalid && m_axi_rready) begin
        n_rbeats++; r_stuck = 0;
        if (r_beat == ar_q[0].len) begin
          void'(ar_q.pop_front()); r_beat = 0; n_rb++;
        end else r_beat++;
      end else r_stuck = m_axi_rvalid;
      // AR channel
      if (m_axi_arvalid) begin
        ar_seen = 1;
        if (first_ar_cyc < 0) first_ar_cyc = cyc;
        m_axi_arready = !stall();
        if (m_axi_arready) begin
          ck("ar_in_model", n_ar < exp_q.size(), 1'b1);
          if (n_ar < exp_q.size()) begin
            ck("ar_addr", m_axi_araddr, exp_q[n_ar].src);
            ck("ar_len", m_axi_arlen, exp_q[n_ar].len);
          end
          ck("ar_size_burst", {m_axi_arsize, m_axi_arburst}, {3'd5, 2'd1});
          ar_q.push_back('{m_axi_araddr, int'(m_axi_arlen)});
          n_ar++;
        end
      end else m_axi_arready = 0;
      // W channel (before AW so W ahead of its AW handshake is caught)
      if (m_axi_wvalid) begin
        if (w_stuck) begin
          ck("w_hold_data", m_axi_wdata, sv_data);
          ck("w_hold_strb", m_axi_wstrb, sv_strb);
          ck("w_hold_last", m_axi_wlast, sv_last);
        end
        m_axi_wready = !stall();
        if (m_axi_wready) begin
          w_stuck = 0;
          ck("w_aw_pending", aw_q.size() != 0 && n_wbursts < exp_q.size(), 1'b1);
          if (aw_q.size() != 0 && n_wbursts < exp_q.size()) begin
            ck("w_data", m_axi_wdata, mk_beat(exp_q[n_wbursts].src + longint'(32 * w_beat)));
            ck("w_strb", m_axi_wstrb, exp_strb());
            ck("w_last", m_axi_wlast, w_beat == aw_q[0].len);
            for (int i = 0; i < STRB_W; i++)
              if (m_axi_wstrb[i])
                wmem[aw_q[0].addr + longint'(32 * w_beat + i)] = m_axi_wdata[8*i +: 8];
            n_wb_total++;
            if (w_beat == aw_q[0].len) begin
              void'(aw_q.pop_front()); w_beat = 0; n_wbursts++; b_pend++;
            end else w_beat++;
          end
        end else begin
          w_stuck = 1; sv_data = m_axi_wdata; sv_strb = m_axi_wstrb; sv_last = m_axi_wlast;
        end
      end else begin
        m_axi_wready = 0; w_stuck = 0;
      end
      // AW channel
      if (m_axi_awvalid) begin
        aw_seen = 1;
        m_axi_awready = !stall();
        if (m_axi_awready) begin
          ck("aw_in_model", n_aw < exp_q.size(), 1'b1);
          if (n_aw < exp_q.size()) begin
            ck("aw_addr", m_axi_awaddr, exp_q[n_aw].dst);
            ck("aw_len", m_axi_awlen, exp_q[n_aw].len);
          end
          ck("aw_size_burst", {m_axi_awsize, m_axi_awburst}, {3'd5, 2'd1});
          ck("aw_after_r", ar_q.size() == 0 && r_beat == 0, 1'b1);
          aw_q.push_back('{m_axi_awaddr, int'(m_axi_awlen)});
          n_aw++;
        end
      end else m_axi_awready = 0;
    end
  end

  // --------------------------------------------------------------------------
  // One descriptor, end to end
  // --------------------------------------------------------------------------
  task automatic run_copy(input longint unsigned s, input longint unsigned d,
                          input longint unsigned n, input bit exp_err);
    int acc_cyc, waited, bad;
    exp_q.delete();
    if (s % 32 == 0 && d % 32 == 0) build_model(s, d, n);
    wmem.delete();
    n_ar = 0; n_aw = 0; n_rb = 0; n_rbeats = 0; n_wbursts = 0; n_wb_total = 0; b_pend = 0;
    n_done = 0; n_err = 0; done_cyc = 0; last_b_cyc = 0; first_ar_cyc = -1;
    ar_seen = 0; aw_seen = 0;
    cur_bytes = n;
    seed = 8'($urandom);
    @(negedge clk);
    dma_req_valid = 1; dma_req_src = s; dma_req_dst = d; dma_req_bytes = 32'(n);
    ck("req_ready", dma_req_ready, 1'b1);
    acc_cyc = cyc;
    @(negedge clk);
    // keep a junk request up while busy: it must be ignored
    dma_req_src = 64'h1234_5678_9ABC_DEF0; dma_req_bytes = 32'd64;
    ck("busy_after_accept", dma_busy, 1'b1);
    ck("ready_low_busy", dma_req_ready, 1'b0);
    @(negedge clk);
    dma_req_valid = 0;
    waited = 0;
    while (n_done + n_err == 0 && waited < 20000) begin
      @(negedge clk); waited++;
    end
    ck("timeout", waited < 20000, 1'b1);
    repeat (4) @(negedge clk);
    if (exp_err) begin
      ck("err_pulse", n_err, 1);
      ck("no_done", n_done, 0);
    end else begin
      ck("done_pulse", n_done, 1);
      ck("no_err", n_err, 0);
      ck("ar_count", n_ar, exp_q.size());
      ck("aw_count", n_aw, exp_q.size());
      bad = 0;
      for (longint unsigned i = 0; i < n; i++)
        if (!wmem.exists(d + i) || wmem[d + i] != src_byte(s + i)) bad++;
      ck("mem_bad_bytes", bad, 0);
      ck("mem_written", wmem.num(), n);
      if (n == 0) begin
        ck("zero_latency", done_cyc - acc_cyc, 2);
        ck("zero_no_axi", ar_seen | aw_seen, 1'b0);
      end else begin
        ck("ar_latency", first_ar_cyc - acc_cyc, 2);
        ck("b_to_done", done_cyc - last_b_cyc, 1);
      end
    end
    ck("idle_ready", dma_req_ready, 1'b1);
    ck("idle_busy", dma_busy, 1'b0);
  endtask

  initial begin
    longint unsigned s, d;
    dma_req_valid = 0; dma_req_src = '0; dma_req_dst = '0; dma_req_bytes = '0;
    rst_n = 0;
    repeat (4) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    ck("rst_ready", dma_req_ready, 1'b1);
    ck("rst_busy", dma_busy, 1'b0);
    ck("rst_pulses", {dma_resp_done, dma_resp_err}, 2'b00);
    ck("rst_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}, 3'b000);
    ck("rst_readies", {m_axi_rready, m_axi_bready}, 2'b00);

    stall_pct = 30;
    run_copy(64'h30_0000_0000, 64'h30_0010_0000, 4096, 0);
    ck("4k_bursts", n_ar, 8);

    stall_pct = 0;
    run_copy(64'h1000, 64'h8000, 40, 0);
    ck("b40_bursts", n_aw, 1);

    run_copy(64'h2000, 64'h3000, 0, 0);

    run_copy(64'h0FC0, 64'h2000, 256, 0);
    ck("fc0_bursts", n_ar, 2);

    inj_burst = 0; inj_beat = 3; stall_pct = 20;
    run_copy(64'h4000, 64'h9000, 1024, 1);
    ck("slverr_drained", n_rbeats, 16);
    ck("slverr_no_aw", aw_seen, 1'b0);
    inj_burst = -1; inj_beat = -1;

    stall_pct = 40;
    run_copy(64'h7_0000_0040, 64'h5_1234_5000, 1000, 0);

    run_copy(64'h5000, 64'h6004, 128, 1);
    ck("misalign_no_axi", ar_seen | aw_seen, 1'b0);

    for (int k = 0; k < 6; k++) begin
      s = {$urandom(), $urandom()};
      d = {$urandom(), $urandom()};
      s[11:0] = 12'(32 * $urandom_range(100, 127));
      d[11:0] = 12'(32 * $urandom_range(90, 127));
      stall_pct = $urandom_range(0, 50);
      run_copy(s, d, longint'($urandom_range(1, 1500)), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
